// File: rtl/vec_operand_regfile_if.sv
// rtl/vec_operand_regfile_if.sv - operand/result bus between the vector register file and the math unit
interface vec_operand_regfile_if #(
    parameter int VW = 512
);
    logic [VW-1:0] A1;
    logic [VW-1:0] A2;
    logic [1:0]    instruction;
    logic [VW-1:0] A3;
    logic [VW-1:0] A4;

    // register file side: drives operands and op code, consumes results
    modport master (
        output A1,
        output A2,
        output instruction,
        input  A3,
        input  A4
    );

    // math unit side
    modport slave (
        input  A1,
        input  A2,
        input  instruction,
        output A3,
        output A4
    );
endinterface

// File: rtl/vec_operand_regfile.sv
// rtl/vec_operand_regfile.sv - vector register file and issue sequencer for the math unit (optional VRF_WR_BLOCK_EN)
module vec_operand_regfile #(
    parameter int NREG  = 4,
    parameter int LANES = 16,
    parameter int W     = 32,
    localparam int RW   = $clog2(NREG),
    localparam int LW   = $clog2(LANES),
    localparam int VW   = LANES * W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [RW-1:0] wr_reg,
    input  logic [LW-1:0] wr_idx,
    input  logic [W-1:0]  wr_data,
    input  logic [RW-1:0] rd_reg,
    input  logic [LW-1:0] rd_idx,
    output logic [W-1:0]  rd_data,
    input  logic          start,
    input  logic [RW-1:0] src1,
    input  logic [RW-1:0] src2,
    input  logic [RW-1:0] dst_hi,
    input  logic [RW-1:0] dst_lo,
    input  logic [1:0]    op,
    output logic          busy,
    output logic          done,
`ifdef VRF_WR_BLOCK_EN
    output logic          wr_err,
`endif
    vec_operand_regfile_if.master mu
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [VW-1:0] regs [NREG];
    logic [1:0]    op_q;
    logic [RW-1:0] dst_hi_q;
    logic [RW-1:0] dst_lo_q;
    logic          accept;
    logic          wb;
    logic          wr_accept;

`ifdef VRF_WR_BLOCK_EN
    // busy mirrors EXEC, so blocking host writes here removes any writeback collision
    assign wr_accept = wr_en & ~busy;
`else
    assign wr_accept = wr_en;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state: accept start only in IDLE, write back only real ops in EXEC
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        wb        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                wb        = (op_q == 2'b01) || (op_q == 2'b10);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // register array: host lane writes, then writeback (lo then hi, so hi wins and both override host)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr_accept) begin
                regs[wr_reg][wr_idx*W +: W] <= wr_data;
            end
            if (wb) begin
                regs[dst_lo_q] <= mu.A4;
                regs[dst_hi_q] <= mu.A3;
            end
        end
    end

    // operand issue, completion handshake and registered host read port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mu.A1          <= '0;
            mu.A2          <= '0;
            mu.instruction <= 2'b00;
            op_q           <= 2'b00;
            dst_hi_q       <= '0;
            dst_lo_q       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            rd_data        <= '0;
`ifdef VRF_WR_BLOCK_EN
            wr_err         <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
            rd_data <= regs[rd_reg][rd_idx*W +: W];
`ifdef VRF_WR_BLOCK_EN
            wr_err  <= wr_en & busy;
`endif
            if (accept) begin
                mu.A1          <= regs[src1];
                mu.A2          <= regs[src2];
                mu.instruction <= op;
                op_q           <= op;
                dst_hi_q       <= dst_hi;
                dst_lo_q       <= dst_lo;
                busy           <= 1'b1;
            end
            if (state == EXEC) begin
                mu.instruction <= 2'b00;
                busy           <= 1'b0;
                done           <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vec_operand_regfile.sv
// tb/tb_vec_operand_regfile.sv - scoreboard bench for vec_operand_regfile
module tb_vec_operand_regfile;

    localparam int NREG  = 4;
    localparam int LANES = 16;
    localparam int W     = 32;
    localparam int VW    = LANES * W;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [1:0]    wr_reg;
    logic [3:0]    wr_idx;
    logic [W-1:0]  wr_data;
    logic [1:0]    rd_reg;
    logic [3:0]    rd_idx;
    logic [W-1:0]  rd_data;
    logic          start;
    logic [1:0]    src1;
    logic [1:0]    src2;
    logic [1:0]    dst_hi;
    logic [1:0]    dst_lo;
    logic [1:0]    op;
    logic          busy;
    logic          done;
`ifdef VRF_WR_BLOCK_EN
    logic          wr_err;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [VW-1:0] a1;
        logic [VW-1:0] a2;
        logic [1:0]    op;
        logic [1:0]    hi;
        logic [1:0]    lo;
    } exp_t;

    exp_t          sb [$];
    logic [VW-1:0] mreg [NREG];

    vec_operand_regfile_if #(.VW(VW)) mif ();

    vec_operand_regfile #(.NREG(NREG), .LANES(LANES), .W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_reg  (wr_reg),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rd_reg  (rd_reg),
        .rd_idx  (rd_idx),
        .rd_data (rd_data),
        .start   (start),
        .src1    (src1),
        .src2    (src2),
        .dst_hi  (dst_hi),
        .dst_lo  (dst_lo),
        .op      (op),
        .busy    (busy),
        .done    (done),
`ifdef VRF_WR_BLOCK_EN
        .wr_err  (wr_err),
`endif
        .mu      (mif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // math unit reference: per-lane 64-bit product or 33-bit sum split into hi/lo words
    function automatic logic [VW-1:0] mu_res(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                             input logic [1:0] o, input logic hi);
        logic [VW-1:0]  r;
        logic [2*W-1:0] p;
        r = '0;
        for (int l = 0; l < LANES; l++) begin
            case (o)
                2'b01:   p = {{W{1'b0}}, a[l*W +: W]} * {{W{1'b0}}, b[l*W +: W]};
                2'b10:   p = {{W{1'b0}}, a[l*W +: W]} + {{W{1'b0}}, b[l*W +: W]};
                default: p = '0;
            endcase
            r[l*W +: W] = hi ? p[2*W-1:W] : p[W-1:0];
        end
        return r;
    endfunction

    always_comb begin
        mif.A3 = mu_res(mif.A1, mif.A2, mif.instruction, 1'b1);
        mif.A4 = mu_res(mif.A1, mif.A2, mif.instruction, 1'b0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [1:0] r, input logic [3:0] i, input logic [W-1:0] d);
        wr_en = 1'b1; wr_reg = r; wr_idx = i; wr_data = d;
        tick();
        wr_en = 1'b0;
        mreg[r][i*W +: W] = d;
    endtask

    task automatic fill_reg(input logic [1:0] r, input logic [W-1:0] base, input logic [W-1:0] step);
        for (int l = 0; l < LANES; l++) begin
            host_write(r, 4'(l), base + step * W'(l));
        end
    endtask

    task automatic read_vec(input logic [1:0] r, output logic [VW-1:0] v);
        v = '0;
        for (int l = 0; l < LANES; l++) begin
            rd_reg = r; rd_idx = 4'(l);
            tick();
            v[l*W +: W] = rd_data;
        end
    endtask

    // one issue: T0 edge checks operands from scoreboard, T1 edge checks completion; optional host write during EXEC
    task automatic exec_op(input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] h,
                           input logic [1:0] l, input logic [1:0] o, input logic keep,
                           input logic hw_en, input logic [1:0] hw_reg, input logic [3:0] hw_idx,
                           input logic [W-1:0] hw_data);
        exp_t          e;
        logic [VW-1:0] eh;
        logic [VW-1:0] el;
        start = 1'b1; src1 = s1; src2 = s2; dst_hi = h; dst_lo = l; op = o;
        e.a1 = mreg[s1]; e.a2 = mreg[s2]; e.op = o; e.hi = h; e.lo = l;
        sb.push_back(e);
        tick();
        if (!keep) start = 1'b0;
        e = sb.pop_front();
        tests_run++;
        if (mif.A1 !== e.a1) begin tests_failed++; $display("FAIL issue_a1: got %h want %h", mif.A1, e.a1); end
        tests_run++;
        if (mif.A2 !== e.a2) begin tests_failed++; $display("FAIL issue_a2: got %h want %h", mif.A2, e.a2); end
        tests_run++;
        if (mif.instruction !== e.op) begin tests_failed++; $display("FAIL issue_instr: got %b want %b", mif.instruction, e.op); end
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0) begin tests_failed++; $display("FAIL issue_busy: got busy=%b done=%b want busy=1 done=0", busy, done); end
        eh = mu_res(e.a1, e.a2, e.op, 1'b1);
        el = mu_res(e.a1, e.a2, e.op, 1'b0);
        if (hw_en) begin
            wr_en = 1'b1; wr_reg = hw_reg; wr_idx = hw_idx; wr_data = hw_data;
        end
        tick();
        wr_en = 1'b0;
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL done_pulse: got done=%b busy=%b want done=1 busy=0", done, busy); end
        tests_run++;
        if (mif.instruction !== 2'b00) begin tests_failed++; $display("FAIL done_instr: got %b want 00", mif.instruction); end
        tests_run++;
        if (mif.A1 !== e.a1 || mif.A2 !== e.a2) begin tests_failed++; $display("FAIL operand_hold: got %h want %h", mif.A1, e.a1); end
`ifdef VRF_WR_BLOCK_EN
        tests_run++;
        if (wr_err !== hw_en) begin tests_failed++; $display("FAIL wr_err: got %b want %b", wr_err, hw_en); end
`else
        if (hw_en) mreg[hw_reg][hw_idx*W +: W] = hw_data;
`endif
        if (e.op == 2'b01 || e.op == 2'b10) begin
            mreg[e.lo] = el;
            mreg[e.hi] = eh;
        end
    endtask

    task automatic verify_all(input string tag);
        logic [VW-1:0] v;
        for (int r = 0; r < NREG; r++) begin
            read_vec(2'(r), v);
            tests_run++;
            if (v !== mreg[r]) begin tests_failed++; $display("FAIL %s_reg%0d: got %h want %h", tag, r, v, mreg[r]); end
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        tests_run++;
        if (mif.A1 !== '0 || mif.A2 !== '0) begin tests_failed++; $display("FAIL reset_operands: got %h want 0", mif.A1); end
        tests_run++;
        if (mif.instruction !== 2'b00 || busy !== 1'b0 || done !== 1'b0 || rd_data !== '0) begin
            tests_failed++; $display("FAIL reset_outputs: got instr=%b busy=%b done=%b rd=%h want 0", mif.instruction, busy, done, rd_data);
        end
        rst = 1'b0;
        verify_all("reset");
    endtask

    task automatic test_load_readback();
        host_write(2'd1, 4'd3, 32'h0000_00FF);
        rd_reg = 2'd1; rd_idx = 4'd3;
        tests_run++;
        if (rd_data !== 32'h0) begin tests_failed++; $display("FAIL rd_latency: got %h want 00000000", rd_data); end
        tick();
        tests_run++;
        if (rd_data !== 32'h0000_00FF) begin tests_failed++; $display("FAIL readback: got %h want 000000ff", rd_data); end
        wr_en = 1'b1; wr_reg = 2'd1; wr_idx = 4'd3; wr_data = 32'hA5A5_0001;
        tick();
        wr_en = 1'b0;
        mreg[1][3*W +: W] = 32'hA5A5_0001;
        tests_run++;
        if (rd_data !== 32'h0000_00FF) begin tests_failed++; $display("FAIL read_during_write: got %h want 000000ff", rd_data); end
        tick();
        tests_run++;
        if (rd_data !== 32'hA5A5_0001) begin tests_failed++; $display("FAIL read_after_write: got %h want a5a50001", rd_data); end
    endtask

    task automatic test_issue_sum();
        logic [VW-1:0] v;
        fill_reg(2'd0, 32'd5, 32'd0);
        fill_reg(2'd1, 32'd7, 32'd0);
        exec_op(2'd0, 2'd1, 2'd2, 2'd3, 2'b10, 1'b0, 1'b0, 2'd0, 4'd0, 32'd0);
        tests_run++;
        if (mif.A1 !== {LANES{32'd5}} || mif.A2 !== {LANES{32'd7}}) begin tests_failed++; $display("FAIL sum_operands: got %h want all 5", mif.A1); end
        read_vec(2'd3, v);
        tests_run++;
        if (v !== {LANES{32'd12}}) begin tests_failed++; $display("FAIL sum_reg3: got %h want all 12", v); end
        read_vec(2'd2, v);
        tests_run++;
        if (v !== '0) begin tests_failed++; $display("FAIL sum_reg2: got %h want 0", v); end
        verify_all("sum");
    endtask

    task automatic test_nop_busy();
        int extra;
        exec_op(2'd2, 2'd3, 2'd0, 2'd1, 2'b00, 1'b1, 1'b0, 2'd0, 4'd0, 32'd0);
        start = 1'b0;
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (done) extra++;
        end
        tests_run++;
        if (extra !== 0 || busy !== 1'b0) begin tests_failed++; $display("FAIL extra_done: got %0d busy=%b want 0", extra, busy); end
        exec_op(2'd3, 2'd3, 2'd0, 2'd1, 2'b11, 1'b0, 1'b0, 2'd0, 4'd0, 32'd0);
        verify_all("nop");
    endtask

    task automatic test_collision();
        logic [VW-1:0] v;
        fill_reg(2'd0, 32'hFFFF_FFF0, 32'd1);
        fill_reg(2'd1, 32'h0000_1000, 32'd1);
        exec_op(2'd0, 2'd1, 2'd2, 2'd2, 2'b01, 1'b0, 1'b0, 2'd0, 4'd0, 32'd0);
        read_vec(2'd2, v);
        tests_run++;
        if (v[W-1:0] !== 32'h0000_0FFF) begin tests_failed++; $display("FAIL same_dst_hi_wins: got %h want 00000fff", v[W-1:0]); end
        exec_op(2'd0, 2'd1, 2'd2, 2'd3, 2'b10, 1'b0, 1'b1, 2'd2, 4'd5, 32'hDEAD_BEEF);
        read_vec(2'd2, v);
        tests_run++;
        if (v[5*W +: W] !== 32'd1) begin tests_failed++; $display("FAIL wb_beats_host: got %h want 00000001", v[5*W +: W]); end
        exec_op(2'd1, 2'd1, 2'd0, 2'd1, 2'b10, 1'b0, 1'b1, 2'd3, 4'd7, 32'hCAFE_0000);
        verify_all("collide");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            exec_op(2'(k), 2'(k + 1), 2'(k + 2), 2'(k + 3), (k == 1) ? 2'b01 : 2'b10,
                    1'b1, 1'b0, 2'd0, 4'd0, 32'd0);
        end
        start = 1'b0;
        tick();
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_tail: got done=%b busy=%b want 0 0", done, busy); end
        verify_all("b2b");
    endtask

    task automatic test_reset_mid();
        logic [VW-1:0] v;
        start = 1'b1; src1 = 2'd0; src2 = 2'd1; dst_hi = 2'd2; dst_lo = 2'd3; op = 2'b10;
        rd_reg = 2'd0; rd_idx = 4'd0;
        tick();
        start = 1'b0;
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (mif.A1 !== '0 || mif.A2 !== '0 || mif.instruction !== 2'b00) begin
            tests_failed++; $display("FAIL async_reset_bus: got instr=%b a1=%h want 0", mif.instruction, mif.A1);
        end
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || rd_data !== '0) begin
            tests_failed++; $display("FAIL async_reset_ctl: got busy=%b done=%b rd=%h want 0", busy, done, rd_data);
        end
        tick();
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_no_done: got %b want 0", done); end
        rst = 1'b0;
        for (int r = 0; r < NREG; r++) mreg[r] = '0;
        tick();
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL reset_abort: got done=%b busy=%b want 0", done, busy); end
        read_vec(2'd3, v);
        tests_run++;
        if (v !== '0) begin tests_failed++; $display("FAIL reset_no_wb: got %h want 0", v); end
        verify_all("rstmid");
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_reg = '0; wr_idx = '0; wr_data = '0;
        rd_reg = '0; rd_idx = '0; start = 1'b0; src1 = '0; src2 = '0;
        dst_hi = '0; dst_lo = '0; op = 2'b00;
        for (int r = 0; r < NREG; r++) mreg[r] = '0;
        test_reset();
        test_load_readback();
        test_issue_sum();
        test_nop_busy();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
